// File: rtl/signal_resample_pkg.sv
// Shared constants and state encoding for the per-antenna mid-bit resampler.
// The capture stage imports the same package so both agree on N, H and the phase width.
package signal_resample_pkg;

  localparam int RATIO = 6;
  localparam int TICKS = 2;
  localparam int PBITS = 4;
  localparam int MAXD  = 1;

  localparam int N = RATIO * TICKS;
  localparam int H = N / 2;

  // g must hold up to 2N; delta needs headroom for the signed wrap of m - m_last
  localparam int GBITS = $clog2(2 * N + 1);
  localparam int DBITS = PBITS + 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACQ  = 2'd1,
    ST_RUN  = 2'd2
  } state_t;

endpackage

// File: rtl/signal_resample_phase_delta.sv
// Signed wrap of (m - m_last) into [-H, H-1], then clamp to +/-MAXD.
// Purely combinational so the capture stage can reuse it.
module phase_delta
  import signal_resample_pkg::*;
(
  input  logic        [PBITS-1:0] m_i,
  input  logic        [PBITS-1:0] m_last_i,
  output logic signed [DBITS-1:0] delta_o,
  output logic                    clamp_o
);

  logic signed [DBITS-1:0] w_diff;
  logic signed [DBITS-1:0] w_wrap;
  logic signed [DBITS-1:0] w_raw;

  always_comb begin
    w_diff = $signed({2'b00, m_i}) - $signed({2'b00, m_last_i});
    w_wrap = (w_diff < 0) ? w_diff + DBITS'(N) : w_diff;
    // Upper half of the circle means a backward step, so 0 -> N-1 reads as -1
    w_raw  = (w_wrap >= DBITS'(H)) ? w_wrap - DBITS'(N) : w_wrap;
  end

  always_comb begin
    delta_o = w_raw;
    clamp_o = 1'b0;
    if (w_raw > DBITS'(MAXD)) begin
      delta_o = DBITS'(MAXD);
      clamp_o = 1'b1;
    end else if (w_raw < -DBITS'(MAXD)) begin
      delta_o = -DBITS'(MAXD);
      clamp_o = 1'b1;
    end
  end

endmodule

// File: rtl/signal_resample.sv
// Picks one mid-bit sample per recovered bit from the DDR sample pair, following
// slow phase drift (including wrap) with slew-limited steps; flags clamped jumps.
module signal_resample
  import signal_resample_pkg::*;
(
  input  logic             clock_i,
  input  logic             reset_i,
  input  logic             enable_i,
  input  logic             sig_n_i,
  input  logic             sig_p_i,
  input  logic             strobe_i,
  input  logic [PBITS-1:0] phase_i,
  input  logic             locked_i,
  output logic             data_o,
  output logic             valid_o,
  output logic             error_o,
  output logic             active_o
);

  state_t r_state;
  state_t w_state_next;

  logic [PBITS-1:0] r_m_last;
  logic [PBITS-1:0] w_m_last_next;
  logic [GBITS-1:0] r_g;
  logic [GBITS-1:0] w_g_next;
  logic [GBITS-1:0] w_g_cur;

  logic r_data;
  logic r_valid;
  logic r_error;
  logic r_active;

  logic w_go;
  logic w_count;
  logic w_emit;
  logic w_sample;
  logic w_err_next;

  logic [PBITS:0]          w_m_sum;
  logic [PBITS-1:0]        w_m;
  logic signed [DBITS-1:0] w_delta;
  logic signed [DBITS-1:0] w_delta_use;
  logic                    w_clamp;
  logic signed [DBITS-1:0] w_ml_sum;
  logic [PBITS-1:0]        w_ml_step;

  assign w_go = enable_i & locked_i;

  // Mid-bit target m = (phase + H) mod N; phase is below N so one subtraction suffices
  assign w_m_sum = {1'b0, phase_i} + (PBITS+1)'(H);
  assign w_m     = (w_m_sum >= (PBITS+1)'(N)) ? PBITS'(w_m_sum - (PBITS+1)'(N))
                                              : w_m_sum[PBITS-1:0];

  phase_delta u_phase_delta (
    .m_i      (w_m),
    .m_last_i (r_m_last),
    .delta_o  (w_delta),
    .clamp_o  (w_clamp)
  );

  always_comb begin
    w_ml_sum = $signed({2'b00, r_m_last}) + w_delta;
    if (w_ml_sum < 0) begin
      w_ml_step = PBITS'(w_ml_sum + DBITS'(N));
    end else if (w_ml_sum >= DBITS'(N)) begin
      w_ml_step = PBITS'(w_ml_sum - DBITS'(N));
    end else begin
      w_ml_step = w_ml_sum[PBITS-1:0];
    end
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: if (w_go) w_state_next = ST_ACQ;
      ST_ACQ: begin
        if (!w_go) begin
          w_state_next = ST_IDLE;
        end else if (strobe_i) begin
          w_state_next = ST_RUN;
        end
      end
      ST_RUN:  if (!w_go) w_state_next = ST_IDLE;
      default: w_state_next = ST_IDLE;
    endcase
  end

  // The strobe cycle already holds sample positions 0 and 1, so it counts down like a RUN cycle
  always_comb begin
    w_count       = 1'b0;
    w_emit        = 1'b0;
    w_sample      = sig_n_i;
    w_err_next    = 1'b0;
    w_g_cur       = r_g;
    w_g_next      = r_g;
    w_delta_use   = '0;
    w_m_last_next = r_m_last;
    case (r_state)
      ST_ACQ: begin
        if (w_go && strobe_i) begin
          w_count       = 1'b1;
          w_g_cur       = GBITS'(w_m);
          w_m_last_next = w_m;
        end
      end
      ST_RUN: begin
        if (w_go) begin
          w_count     = 1'b1;
          w_delta_use = w_delta;
        end
      end
      default: w_count = 1'b0;
    endcase
    if (w_count) begin
      if (w_g_cur >= GBITS'(2)) begin
        w_g_next = w_g_cur - GBITS'(2);
      end else begin
        w_emit     = 1'b1;
        w_sample   = w_g_cur[0] ? sig_p_i : sig_n_i;
        w_g_next   = w_g_cur + GBITS'(N) + GBITS'(w_delta_use) - GBITS'(2);
        if (r_state == ST_RUN) begin
          w_err_next    = w_clamp;
          w_m_last_next = w_ml_step;
        end
      end
    end
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      r_m_last <= '0;
      r_g      <= '0;
      r_data   <= 1'b0;
      r_valid  <= 1'b0;
      r_error  <= 1'b0;
      r_active <= 1'b0;
    end else begin
      r_m_last <= w_m_last_next;
      r_g      <= w_g_next;
      if (w_emit) r_data <= w_sample;
      r_valid  <= w_emit;
      r_error  <= w_err_next;
      r_active <= (w_state_next == ST_RUN);
    end
  end

  assign data_o   = r_data;
  assign valid_o  = r_valid;
  assign error_o  = r_error;
  assign active_o = r_active;

endmodule

// File: tb/tb_signal_resample.sv
// Directed bench for signal_resample: emission timing, sample choice, drift, wrap,
// clamping and lock loss, with hand-computed emission schedules per scenario.
module tb_signal_resample;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic       sn = 1'b0;
  logic       sp = 1'b0;
  logic       strb = 1'b0;
  logic [3:0] phase = 4'd0;
  logic       lock = 1'b0;
  logic       data;
  logic       valid;
  logic       err;
  logic       active;

  int n_vec = 0;
  int n_bad = 0;

  logic hist_n [0:63];
  logic hist_p [0:63];

  signal_resample dut (
    .clock_i  (clk),
    .reset_i  (rst),
    .enable_i (en),
    .sig_n_i  (sn),
    .sig_p_i  (sp),
    .strobe_i (strb),
    .phase_i  (phase),
    .locked_i (lock),
    .data_o   (data),
    .valid_o  (valid),
    .error_o  (err),
    .active_o (active)
  );

  always #5 clk = ~clk;

  // Random sample pair for this cycle, remembered so emitted data can be checked
  task automatic tick(input int idx);
    sn = 1'($urandom_range(0, 1));
    sp = 1'($urandom_range(0, 1));
    if (idx >= 0 && idx < 64) begin
      hist_n[idx] = sn;
      hist_p[idx] = sp;
    end
    @(posedge clk);
    #1;
  endtask

  // Leave any previous state through IDLE and park in ACQ
  task automatic arm(input logic [3:0] ph);
    strb  = 1'b0;
    lock  = 1'b1;
    en    = 1'b0;
    phase = ph;
    tick(-1);
    tick(-1);
    en = 1'b1;
    tick(-1);
    tick(-1);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int c = 0; c < 3; c++) begin
      en    = 1'($urandom_range(0, 1));
      lock  = 1'($urandom_range(0, 1));
      strb  = 1'($urandom_range(0, 1));
      phase = 4'($urandom_range(0, 11));
      tick(-1);
      n_vec++;
      if ({data, valid, err, active} !== 4'b0000) begin
        n_bad++;
        $display("FAIL reset_outputs c=%0d: got %b expected 0000", c, {data, valid, err, active});
      end
    end
    rst = 1'b0; en = 1'b0; lock = 1'b1; phase = 4'd3;
    for (int c = 0; c < 4; c++) begin
      strb = 1'b1;
      tick(-1);
      n_vec++;
      if ({valid, active} !== 2'b00) begin
        n_bad++;
        $display("FAIL idle_no_enable c=%0d: got valid/active %b expected 00", c, {valid, active});
      end
    end
    en = 1'b1; lock = 1'b0; strb = 1'b1;
    tick(-1);
    n_vec++;
    if ({valid, active} !== 2'b00) begin
      n_bad++;
      $display("FAIL idle_no_lock: got valid/active %b expected 00", {valid, active});
    end
    strb = 1'b0;
  endtask

  // Phase 3 -> m 9: emit sig_p every 6 cycles from c=4; a strobe inside RUN is ignored
  task automatic test_constant_phase();
    int   ec [5] = '{4, 10, 16, 22, 28};
    logic exp_v;
    logic last_d = 1'b0;
    bit   have_d = 1'b0;
    arm(4'd3);
    for (int c = 0; c < 30; c++) begin
      strb = (c == 0 || c == 7);
      tick(c);
      exp_v = 1'b0;
      foreach (ec[k]) if (ec[k] == c) exp_v = 1'b1;
      n_vec++;
      if (valid !== exp_v) begin
        n_bad++;
        $display("FAIL const_valid c=%0d: got %b expected %b", c, valid, exp_v);
      end
      if (exp_v) begin
        last_d = hist_p[c];
        have_d = 1'b1;
      end
      if (have_d) begin
        n_vec++;
        if (data !== last_d) begin
          n_bad++;
          $display("FAIL const_data c=%0d: got %b expected %b", c, data, last_d);
        end
      end
      n_vec++;
      if ({err, active} !== 2'b01) begin
        n_bad++;
        $display("FAIL const_err_active c=%0d: got %b expected 01", c, {err, active});
      end
    end
    strb = 1'b0;
  endtask

  // 3 -> 4 seen at the c=10 emission: next one 13 samples later, on sig_n at c=17
  task automatic test_phase_step();
    int   ec [4] = '{4, 10, 17, 23};
    bit   ep [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
    logic exp_v;
    logic exp_d;
    arm(4'd3);
    for (int c = 0; c < 25; c++) begin
      strb  = (c == 0);
      phase = (c < 5) ? 4'd3 : 4'd4;
      tick(c);
      exp_v = 1'b0;
      exp_d = 1'b0;
      foreach (ec[k]) if (ec[k] == c) begin
        exp_v = 1'b1;
        exp_d = ep[k] ? hist_p[c] : hist_n[c];
      end
      n_vec++;
      if (valid !== exp_v) begin
        n_bad++;
        $display("FAIL step_valid c=%0d: got %b expected %b", c, valid, exp_v);
      end
      if (exp_v) begin
        n_vec++;
        if (data !== exp_d) begin
          n_bad++;
          $display("FAIL step_data c=%0d: got %b expected %b", c, data, exp_d);
        end
      end
      n_vec++;
      if (err !== 1'b0) begin
        n_bad++;
        $display("FAIL step_err c=%0d: got %b expected 0", c, err);
      end
    end
    strb = 1'b0;
  endtask

  // m 11 -> 0 gives a 13-sample gap (c=11 -> 18), m 0 -> 11 an 11-sample gap (c=24 -> 29)
  task automatic test_phase_wrap();
    int   ec [6] = '{5, 11, 18, 24, 29, 35};
    bit   ep [6] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    logic exp_v;
    logic exp_d;
    int   pulses = 0;
    arm(4'd5);
    for (int c = 0; c < 37; c++) begin
      strb  = (c == 0);
      phase = (c < 6) ? 4'd5 : ((c < 19) ? 4'd6 : 4'd5);
      tick(c);
      exp_v = 1'b0;
      exp_d = 1'b0;
      foreach (ec[k]) if (ec[k] == c) begin
        exp_v = 1'b1;
        exp_d = ep[k] ? hist_p[c] : hist_n[c];
      end
      if (valid === 1'b1) pulses++;
      n_vec++;
      if (valid !== exp_v) begin
        n_bad++;
        $display("FAIL wrap_valid c=%0d: got %b expected %b", c, valid, exp_v);
      end
      if (exp_v) begin
        n_vec++;
        if (data !== exp_d) begin
          n_bad++;
          $display("FAIL wrap_data c=%0d: got %b expected %b", c, data, exp_d);
        end
      end
      n_vec++;
      if (err !== 1'b0) begin
        n_bad++;
        $display("FAIL wrap_err c=%0d: got %b expected 0", c, err);
      end
    end
    n_vec++;
    if (pulses != 6) begin
      n_bad++;
      $display("FAIL wrap_pulse_count: got %0d expected 6", pulses);
    end
    strb = 1'b0;
  endtask

  // m 9 -> 1 is a +4 jump: three clamped +1 steps (errors at c=10,17,23), then one clean +1
  task automatic test_clamp();
    int   ec [6] = '{4, 10, 17, 23, 30, 36};
    bit   ep [6] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    int   ee [3] = '{10, 17, 23};
    logic exp_v;
    logic exp_d;
    logic exp_e;
    arm(4'd3);
    for (int c = 0; c < 38; c++) begin
      strb  = (c == 0);
      phase = (c < 5) ? 4'd3 : 4'd7;
      tick(c);
      exp_v = 1'b0;
      exp_d = 1'b0;
      exp_e = 1'b0;
      foreach (ec[k]) if (ec[k] == c) begin
        exp_v = 1'b1;
        exp_d = ep[k] ? hist_p[c] : hist_n[c];
      end
      foreach (ee[k]) if (ee[k] == c) exp_e = 1'b1;
      n_vec++;
      if (valid !== exp_v) begin
        n_bad++;
        $display("FAIL clamp_valid c=%0d: got %b expected %b", c, valid, exp_v);
      end
      if (exp_v) begin
        n_vec++;
        if (data !== exp_d) begin
          n_bad++;
          $display("FAIL clamp_data c=%0d: got %b expected %b", c, data, exp_d);
        end
      end
      n_vec++;
      if (err !== exp_e) begin
        n_bad++;
        $display("FAIL clamp_err c=%0d: got %b expected %b", c, err, exp_e);
      end
    end
    strb = 1'b0;
  endtask

  // Lock lost on the c=10 emission cycle: no pulse, drop to IDLE, wait in ACQ until strobe at c=21
  task automatic test_lock_drop();
    logic exp_v;
    logic exp_a;
    arm(4'd3);
    for (int c = 0; c < 28; c++) begin
      strb = (c == 0 || c == 21);
      lock = (c != 10);
      tick(c);
      exp_v = (c == 4 || c == 25);
      exp_a = (c < 10 || c >= 21);
      n_vec++;
      if ({valid, active} !== {exp_v, exp_a}) begin
        n_bad++;
        $display("FAIL lock_valid_active c=%0d: got %b expected %b", c, {valid, active}, {exp_v, exp_a});
      end
      if (exp_v) begin
        n_vec++;
        if (data !== hist_p[c]) begin
          n_bad++;
          $display("FAIL lock_data c=%0d: got %b expected %b", c, data, hist_p[c]);
        end
      end
    end
    strb = 1'b0;
    lock = 1'b1;
  endtask

  initial begin
    test_reset();
    test_constant_phase();
    test_phase_step();
    test_phase_wrap();
    test_clamp();
    test_lock_drop();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
